// File: rtl/mmio_pkg.sv
// mmio_pkg: shared FSM state type and constants for the MMIO bridge.
package mmio_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  localparam logic [1:0]  IO_REGION    = 2'b11;
  localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;
endpackage

// File: rtl/mmio_timer.sv
// mmio_timer: wait-state watchdog for an MMIO access (built only with MMIO_TIMEOUT_EN).
// Ports: clk, rst (sync, active high), clr_i zeroes the count, en_i counts one
// cycle, expired_o is high during the CYC-th enabled cycle since the last clear.
`ifdef MMIO_TIMEOUT_EN
module mmio_timer #(
  parameter int CYC = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d     = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  assign expired_o = en_i && (cnt_q == CW'(CYC - 1));
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule
`endif

// File: rtl/mmio_bridge.sv
// mmio_bridge: decodes the CPU I/O window into NUM_CH channels and runs each access through an FSM.
// Ports: clk, rst (sync, active high); cpu_* request side (addr, wdata, we, re in;
// rdata, stall out); io_* peripheral side (one-hot cs, rw_n, addr, wdata out;
// flattened rdata and per-channel ready in); io_err_o sticky decode/timeout error.
// Optional: define MMIO_TIMEOUT_EN to abort accesses whose ready never arrives.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int NUM_CH      = 4,
  parameter int CH_ADDR_W   = 2,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        cpu_addr_i,
  input  logic [DATA_W-1:0]        cpu_wdata_i,
  input  logic                     cpu_we_i,
  input  logic                     cpu_re_i,
  output logic [DATA_W-1:0]        cpu_rdata_o,
  output logic                     cpu_stall_o,
  output logic [NUM_CH-1:0]        io_cs_o,
  output logic                     io_rw_n_o,
  output logic [CH_ADDR_W-1:0]     io_addr_o,
  output logic [DATA_W-1:0]        io_wdata_o,
  input  logic [NUM_CH*DATA_W-1:0] io_rdata_i,
  input  logic [NUM_CH-1:0]        io_ready_i,
  output logic                     io_err_o
);
  localparam int CH_SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  state_e                state_q, state_d;
  logic [CH_SEL_W-1:0]   ch_q, ch_d;
  logic [CH_ADDR_W-1:0]  off_q, off_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  rw_n_q, rw_n_d;
  logic                  err_q, err_d;
  logic                  hit, bad_ch, ready_sel, expired;
  logic [CH_SEL_W-1:0]   req_ch;
  logic [DATA_W-1:0]     sel_rdata;
  logic                  unused_addr;
  assign unused_addr = ^cpu_addr_i;
  assign hit       = (cpu_addr_i[ADDR_W-1 -: 2] == IO_REGION) && (cpu_re_i || cpu_we_i);
  assign req_ch    = cpu_addr_i[CH_ADDR_W +: CH_SEL_W];
  // Non-power-of-two channel counts leave select codes with no peripheral behind them.
  assign bad_ch    = int'(req_ch) >= NUM_CH;
  assign ready_sel = io_ready_i[ch_q];
  assign sel_rdata = io_rdata_i[int'(ch_q)*DATA_W +: DATA_W];
`ifdef MMIO_TIMEOUT_EN
  mmio_timer #(.CYC(TIMEOUT_CYC)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q != ACCESS),
    .en_i      (state_q == ACCESS),
    .expired_o (expired)
  );
`else
  localparam int unused_timeout = TIMEOUT_CYC;
  assign expired = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rw_n_d  = rw_n_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (hit) begin
        ch_d    = req_ch;
        off_d   = cpu_addr_i[CH_ADDR_W-1:0];
        wdata_d = cpu_wdata_i;
        rw_n_d  = cpu_re_i;
        rdata_d = '0;
        state_d = bad_ch ? DONE : ACCESS;
        err_d   = err_q | bad_ch;
      end
      ACCESS: if (ready_sel) begin
        rdata_d = rw_n_q ? sel_rdata : '0;
        state_d = DONE;
      end else if (expired) begin
        rdata_d = DATA_W'(TIMEOUT_DATA);
        err_d   = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rw_n_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rw_n_q  <= rw_n_d;
      err_q   <= err_d;
    end
  end
  assign cpu_stall_o = (state_q == ACCESS) || ((state_q == IDLE) && hit);
  assign cpu_rdata_o = (state_q == DONE) ? rdata_q : '0;
  assign io_cs_o     = (state_q == ACCESS) ? NUM_CH'(1) << ch_q : '0;
  assign io_rw_n_o   = rw_n_q;
  assign io_addr_o   = off_q;
  assign io_wdata_o  = wdata_q;
  assign io_err_o    = err_q;
endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: scoreboard bench for mmio_bridge with three channels, leaving select code 3 undecoded.
module tb_mmio_bridge;
  import mmio_pkg::*;
  typedef struct {
    logic [15:0] data;
    logic        err;
    int          done_cyc;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, io_wdata;
  logic        cpu_we, cpu_re, cpu_stall, io_rw_n, io_err;
  logic [2:0]  io_cs, io_ready;
  logic [1:0]  io_addr;
  logic [47:0] io_rdata;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  mmio_bridge #(.DATA_W(16), .ADDR_W(16), .NUM_CH(3), .CH_ADDR_W(2), .TIMEOUT_CYC(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_we_i    (cpu_we),
    .cpu_re_i    (cpu_re),
    .cpu_rdata_o (cpu_rdata),
    .cpu_stall_o (cpu_stall),
    .io_cs_o     (io_cs),
    .io_rw_n_o   (io_rw_n),
    .io_addr_o   (io_addr),
    .io_wdata_o  (io_wdata),
    .io_rdata_i  (io_rdata),
    .io_ready_i  (io_ready),
    .io_err_o    (io_err)
  );
  task automatic run_access(input string name, input logic [15:0] addr, input logic [15:0] wd,
                            input logic we, input logic re, input int waits, input int exp_done,
                            input logic [15:0] exp_data, input logic exp_err);
    int ch, cyc, acc;
    bit done;
    exp_t e;
    logic [2:0] exp_cs;
    ch = int'(addr[3:2]);
    exp_cs = (ch < 3) ? 3'(1 << ch) : 3'b000;
    sb.push_back('{exp_data, exp_err, exp_done});
    @(posedge clk); #1;
    cpu_addr = addr; cpu_wdata = wd; cpu_we = we; cpu_re = re;
    io_ready = (waits == 0) ? 3'b111 : ~exp_cs;
    cyc = 0; acc = 0; done = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      if (cyc == 0) begin
        checks++;
        if (cpu_stall !== 1'b1) begin errors++; $display("FAIL %s req_stall: got %b want 1", name, cpu_stall); end
      end
      if (cpu_stall === 1'b0) begin
        done = 1;
        e = sb.pop_front();
        checks += 5;
        if (cyc !== e.done_cyc) begin errors++; $display("FAIL %s done_cycle: got %0d want %0d", name, cyc, e.done_cyc); end
        if (cpu_rdata !== e.data) begin errors++; $display("FAIL %s rdata: got %h want %h", name, cpu_rdata, e.data); end
        if (io_err !== e.err) begin errors++; $display("FAIL %s io_err: got %b want %b", name, io_err, e.err); end
        if (io_cs !== 3'b000) begin errors++; $display("FAIL %s done_cs: got %b want 000", name, io_cs); end
        if (acc !== e.done_cyc - 1) begin errors++; $display("FAIL %s cs_cycles: got %0d want %0d", name, acc, e.done_cyc - 1); end
      end else if (io_cs !== 3'b000) begin
        acc++;
        if (acc == 1) begin
          checks += 4;
          if (io_cs !== exp_cs) begin errors++; $display("FAIL %s io_cs: got %b want %b", name, io_cs, exp_cs); end
          if (io_rw_n !== re) begin errors++; $display("FAIL %s io_rw_n: got %b want %b", name, io_rw_n, re); end
          if (io_addr !== addr[1:0]) begin errors++; $display("FAIL %s io_addr: got %h want %h", name, io_addr, addr[1:0]); end
          if (io_wdata !== wd) begin errors++; $display("FAIL %s io_wdata: got %h want %h", name, io_wdata, wd); end
        end
      end
      if (!done) begin
        @(posedge clk); #1;
        cyc++;
        if (io_cs !== 3'b000 && acc >= waits) io_ready = 3'b111;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s completion: got none want done by cycle %0d", name, exp_done);
      void'(sb.pop_front());
    end
    @(posedge clk); #1;
    cpu_we = 0; cpu_re = 0; io_ready = 3'b000;
  endtask
  task automatic test_reset();
    rst = 1; cpu_addr = 0; cpu_wdata = 0; cpu_we = 0; cpu_re = 0; io_ready = 0;
    io_rdata = {16'hBEEF, 16'h5A5A, 16'h00A5};
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 7;
    if (io_cs !== 3'b000) begin errors++; $display("FAIL reset io_cs: got %b want 000", io_cs); end
    if (io_rw_n !== 1'b1) begin errors++; $display("FAIL reset io_rw_n: got %b want 1", io_rw_n); end
    if (io_addr !== 2'b00) begin errors++; $display("FAIL reset io_addr: got %h want 0", io_addr); end
    if (io_wdata !== 16'h0) begin errors++; $display("FAIL reset io_wdata: got %h want 0", io_wdata); end
    if (cpu_rdata !== 16'h0) begin errors++; $display("FAIL reset cpu_rdata: got %h want 0", cpu_rdata); end
    if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset cpu_stall: got %b want 0", cpu_stall); end
    if (io_err !== 1'b0) begin errors++; $display("FAIL reset io_err: got %b want 0", io_err); end
    @(posedge clk); #1;
    rst = 0;
  endtask
  task automatic test_read_zero_wait();
    run_access("read0", 16'hC001, 16'h0000, 0, 1, 0, 2, 16'h00A5, 0);
  endtask
  task automatic test_write_wait();
    run_access("write3", 16'hC006, 16'h1234, 1, 0, 3, 5, 16'h0000, 0);
  endtask
  task automatic test_non_io();
    @(posedge clk); #1;
    cpu_addr = 16'h8000; cpu_wdata = 16'hFFFF; cpu_we = 1; io_ready = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks += 2;
      if (cpu_stall !== 1'b0) begin errors++; $display("FAIL non_io stall: got %b want 0", cpu_stall); end
      if (io_cs !== 3'b000) begin errors++; $display("FAIL non_io io_cs: got %b want 000", io_cs); end
    end
    @(posedge clk); #1;
    cpu_we = 0; io_ready = 3'b000;
  endtask
  task automatic test_decode_error();
    run_access("decode_err", 16'hC00C, 16'h7777, 0, 1, 0, 1, 16'h0000, 1);
  endtask
  task automatic test_back_to_back();
    run_access("b2b_read", 16'hC008, 16'h0000, 0, 1, 1, 3, 16'hBEEF, 1);
    run_access("b2b_write", 16'hC005, 16'h4321, 1, 0, 0, 2, 16'h0000, 1);
    run_access("b2b_rw_both", 16'hC00A, 16'h1111, 1, 1, 2, 4, 16'hBEEF, 1);
  endtask
  task automatic test_reset_mid_access();
    @(posedge clk); #1;
    cpu_addr = 16'hC004; cpu_re = 1; io_ready = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1; cpu_re = 0;
    @(negedge clk);
    checks++;
    if (io_cs !== 3'b010) begin errors++; $display("FAIL rst_mid pre_cs: got %b want 010", io_cs); end
    @(negedge clk);
    checks += 5;
    if (io_cs !== 3'b000) begin errors++; $display("FAIL rst_mid io_cs: got %b want 000", io_cs); end
    if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_mid stall: got %b want 0", cpu_stall); end
    if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst_mid state: got %0d want %0d", dut.state_q, IDLE); end
    if (io_err !== 1'b0) begin errors++; $display("FAIL rst_mid io_err: got %b want 0", io_err); end
    if (cpu_rdata !== 16'h0) begin errors++; $display("FAIL rst_mid rdata: got %h want 0", cpu_rdata); end
    @(posedge clk); #1;
    rst = 0;
  endtask
  task automatic test_timeout();
`ifdef MMIO_TIMEOUT_EN
    run_access("timeout", 16'hC009, 16'h0000, 0, 1, 1000, 16, 16'hDEAD, 1);
`else
    @(posedge clk); #1;
    cpu_addr = 16'hC009; cpu_re = 1; io_ready = 3'b000;
    repeat (100) @(posedge clk);
    @(negedge clk);
    checks += 2;
    if (cpu_stall !== 1'b1) begin errors++; $display("FAIL no_timeout stall: got %b want 1", cpu_stall); end
    if (io_cs !== 3'b100) begin errors++; $display("FAIL no_timeout io_cs: got %b want 100", io_cs); end
    @(posedge clk); #1;
    rst = 1; cpu_re = 0;
    @(posedge clk); #1;
    rst = 0;
`endif
  endtask
  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_non_io();
    test_decode_error();
    test_back_to_back();
    test_reset_mid_access();
    test_timeout();
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: got %0d pending want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
